// File: rtl/dmem_responder.sv
// Data-memory target for MEM-stage load/store requests.
// Word array, little-endian lanes, programmable wait states.
module dmem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2,
  parameter int ADDR_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [2:0]        req_mode_i,
  input  logic [31:0]       req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [31:0]       rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              anomaly_o
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT =
    (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t r_state, w_next;
  logic [3:0] r_cnt, w_cnt_nxt;

  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [2:0]        r_mode;
  logic [31:0]       r_wdata;

  logic [31:0] r_mem [DEPTH];

  logic              w_acc, w_enter;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [2:0]        w_mode;
  logic [31:0]       w_wdata;
  logic              w_bad_mode, w_mis, w_oor, w_err;
  logic [IW-1:0]     w_idx;
  logic [1:0]        w_lane;
  logic [31:0]       w_word, w_rdata, w_wrep;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [3:0]        w_be;

  assign req_ready_o = (r_state == S_IDLE) & ~rst_i;
  assign w_acc = req_valid_i & req_ready_o;
  assign w_enter = (r_state != S_RESP) && (w_next == S_RESP);

  // With zero wait states RESP is entered on the accept edge,
  // so the live request is used before it lands in the capture regs.
  assign w_we    = (r_state == S_IDLE) ? req_we_i    : r_we;
  assign w_addr  = (r_state == S_IDLE) ? req_addr_i  : r_addr;
  assign w_mode  = (r_state == S_IDLE) ? req_mode_i  : r_mode;
  assign w_wdata = (r_state == S_IDLE) ? req_wdata_i : r_wdata;

  assign w_bad_mode = w_we ? (w_mode > 3'd2)
                           : (w_mode == 3'd3 || w_mode > 3'd5);
  assign w_mis = (w_mode[1:0] == 2'd1 && w_addr[0]) ||
                 (w_mode[1:0] == 2'd2 && w_addr[1:0] != 2'd0);
  assign w_oor = |w_addr[ADDR_W-1:IW+2];
  assign w_err = w_bad_mode | w_mis | w_oor;

  assign w_idx  = w_addr[IW+1:2];
  assign w_lane = w_addr[1:0];
  assign w_word = r_mem[w_idx];
  assign w_byte = w_word[{w_lane, 3'b000} +: 8];
  assign w_half = w_word[{w_lane[1], 4'b0000} +: 16];

  always_comb begin
    w_rdata = '0;
    case (w_mode)
      3'd0: w_rdata = {{24{w_byte[7]}}, w_byte};
      3'd1: w_rdata = {{16{w_half[15]}}, w_half};
      3'd2: w_rdata = w_word;
      3'd4: w_rdata = {24'd0, w_byte};
      3'd5: w_rdata = {16'd0, w_half};
      default: w_rdata = '0;
    endcase
    if (w_we || w_err) w_rdata = '0;
  end

  always_comb begin
    w_be   = 4'b0000;
    w_wrep = w_wdata;
    case (w_mode)
      3'd0: begin
        w_be   = 4'b0001 << w_lane;
        w_wrep = {4{w_wdata[7:0]}};
      end
      3'd1: begin
        w_be   = 4'b0011 << w_lane;
        w_wrep = {2{w_wdata[15:0]}};
      end
      3'd2: w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          if (LATENCY == 0) begin
            w_next = S_RESP;
          end else begin
            w_next    = S_WAIT;
            w_cnt_nxt = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) w_next = S_RESP;
        else w_cnt_nxt = r_cnt - 4'd1;
      end
      S_RESP: begin
        if (rsp_ready_i) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_mode      <= 3'd0;
      r_wdata     <= '0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
      anomaly_o   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      if (w_acc) begin
        r_we    <= req_we_i;
        r_addr  <= req_addr_i;
        r_mode  <= req_mode_i;
        r_wdata <= req_wdata_i;
      end
      if (w_enter) begin
        rsp_valid_o <= 1'b1;
        rsp_rdata_o <= w_rdata;
        rsp_err_o   <= w_err;
        if (w_err) anomaly_o <= 1'b1;
      end else if (r_state == S_RESP && rsp_ready_i) begin
        rsp_valid_o <= 1'b0;
        rsp_rdata_o <= '0;
        rsp_err_o   <= 1'b0;
      end
    end
  end

  // Storage is never reset; a reset edge must not commit a store.
  always_ff @(posedge clk_i) begin
    if (w_enter && !rst_i && w_we && !w_err) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wrep[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder.
// Covers LATENCY=2 and LATENCY=0 instances.
module tb_dmem_responder;

  logic        clk, rst;
  logic        req_valid, req_we, rsp_ready;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_mode;
  logic        req_ready, rsp_valid, rsp_err, anomaly;
  logic [31:0] rsp_rdata;

  logic        req_valid0, req_we0, rsp_ready0;
  logic [31:0] req_addr0, req_wdata0;
  logic [2:0]  req_mode0;
  logic        req_ready0, rsp_valid0, rsp_err0, anomaly0;
  logic [31:0] rsp_rdata0;

  typedef struct packed {
    logic [31:0] rd;
    logic        er;
  } exp_t;

  exp_t sb[$];
  int n_pass = 0;
  int n_tot  = 0;

  dmem_responder #(.DEPTH(1024), .LATENCY(2), .ADDR_W(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_we_i(req_we), .req_addr_i(req_addr),
    .req_mode_i(req_mode), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .anomaly_o(anomaly)
  );

  dmem_responder #(.DEPTH(1024), .LATENCY(0), .ADDR_W(32)) dut0 (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid0), .req_ready_o(req_ready0),
    .req_we_i(req_we0), .req_addr_i(req_addr0),
    .req_mode_i(req_mode0), .req_wdata_i(req_wdata0),
    .rsp_valid_o(rsp_valid0), .rsp_ready_i(rsp_ready0),
    .rsp_rdata_o(rsp_rdata0), .rsp_err_o(rsp_err0),
    .anomaly_o(anomaly0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one request, waits for the response, returns it, then
  // consumes it with a single ready edge. lat counts the accept edge
  // as edge 1; -1 means no response arrived.
  task automatic run(input logic we, input logic [31:0] a,
                     input logic [2:0] m, input logic [31:0] wd,
                     output logic [31:0] rd, output logic er,
                     output int lat);
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_mode  = m;
    req_wdata = wd;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = 32'hFFFF_FFFF;
    req_mode  = 3'd7;
    lat = 1;
    while (!rsp_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!rsp_valid) lat = -1;
    rd = rsp_rdata;
    er = rsp_err;
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tot++;
    if ({req_ready, rsp_valid, rsp_err, anomaly, rsp_rdata} !== 36'd0) begin
      $display("FAIL reset_outs got rdy=%b v=%b e=%b a=%b rd=%h want all 0",
               req_ready, rsp_valid, rsp_err, anomaly, rsp_rdata);
    end else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_tot++;
    if (req_ready !== 1'b1 || req_ready0 !== 1'b1) begin
      $display("FAIL reset_release got rdy=%b rdy0=%b want 1 1",
               req_ready, req_ready0);
    end else n_pass++;
  endtask

  task automatic test_sw_lw;
    logic [31:0] rd;
    logic er;
    int lat;
    exp_t e;
    sb.push_back({32'h0, 1'b0});
    run(1'b1, 32'h10, 3'd2, 32'hDEAD_BEEF, rd, er, lat);
    e = sb.pop_front();
    n_tot++;
    if (rd !== e.rd || er !== e.er || lat !== 3) begin
      $display("FAIL sw_10 got rd=%h e=%b lat=%0d want %h %b 3",
               rd, er, lat, e.rd, e.er);
    end else n_pass++;
    sb.push_back({32'hDEAD_BEEF, 1'b0});
    run(1'b0, 32'h10, 3'd2, 32'h0, rd, er, lat);
    e = sb.pop_front();
    n_tot++;
    if (rd !== e.rd || er !== e.er || lat !== 3) begin
      $display("FAIL lw_10 got rd=%h e=%b lat=%0d want %h %b 3",
               rd, er, lat, e.rd, e.er);
    end else n_pass++;
  endtask

  task automatic test_lanes;
    logic        t_we [11];
    logic [31:0] t_a  [11];
    logic [2:0]  t_m  [11];
    logic [31:0] t_wd [11];
    logic [31:0] t_rd [11];
    logic [31:0] rd;
    logic er;
    int lat;
    exp_t e;
    t_we = '{1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0};
    t_a  = '{32'h12, 32'h12, 32'h12, 32'h12, 32'h12, 32'h10,
             32'h10, 32'h14, 32'h16, 32'h14, 32'h16};
    t_m  = '{3'd0, 3'd0, 3'd4, 3'd5, 3'd1, 3'd2,
             3'd0, 3'd2, 3'd1, 3'd2, 3'd1};
    t_wd = '{32'hFFFF_FF80, 0, 0, 0, 0, 0,
             0, 32'h0, 32'h7777_A5C3, 0, 0};
    t_rd = '{32'h0, 32'hFFFF_FF80, 32'h0000_0080, 32'h0000_DE80,
             32'hFFFF_DE80, 32'hDE80_BEEF, 32'hFFFF_FFEF,
             32'h0, 32'h0, 32'hA5C3_0000, 32'hFFFF_A5C3};
    for (int i = 0; i < 11; i++) begin
      sb.push_back({t_rd[i], 1'b0});
      run(t_we[i], t_a[i], t_m[i], t_wd[i], rd, er, lat);
      e = sb.pop_front();
      n_tot++;
      if (rd !== e.rd || er !== e.er) begin
        $display("FAIL lane_%0d got rd=%h e=%b want %h %b",
                 i, rd, er, e.rd, e.er);
      end else n_pass++;
    end
  endtask

  task automatic test_backpressure;
    int n;
    exp_t e;
    sb.push_back({32'hDE80_BEEF, 1'b0});
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h10;
    req_mode  = 3'd2;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    e = sb.pop_front();
    for (int c = 0; c < 5; c++) begin
      n_tot++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== e.rd ||
          rsp_err !== e.er || req_ready !== 1'b0) begin
        $display("FAIL bp_hold_%0d got v=%b rd=%h e=%b rdy=%b want 1 %h %b 0",
                 c, rsp_valid, rsp_rdata, rsp_err, req_ready, e.rd, e.er);
      end else n_pass++;
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    n_tot++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || req_ready !== 1'b1) begin
      $display("FAIL bp_release got v=%b rd=%h rdy=%b want 0 0 1",
               rsp_valid, rsp_rdata, req_ready);
    end else n_pass++;
  endtask

  task automatic test_errors;
    logic        t_we [9];
    logic [31:0] t_a  [9];
    logic [2:0]  t_m  [9];
    logic [31:0] t_wd [9];
    exp_t        t_e  [9];
    logic        t_an [9];
    logic [31:0] rd;
    logic er;
    int lat;
    exp_t e;
    t_we = '{1, 0, 1, 0, 0, 1, 0, 1, 0};
    t_a  = '{32'h0, 32'h11, 32'h1000, 32'h0, 32'h0,
             32'h0, 32'h2, 32'hFFC, 32'hFFC};
    t_m  = '{3'd2, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd2, 3'd2, 3'd2};
    t_wd = '{32'h1122_3344, 0, 32'hFFFF_FFFF, 0, 0,
             32'hFFFF_FFFF, 0, 32'hCAFE_F00D, 0};
    t_e  = '{{32'h0, 1'b0}, {32'h0, 1'b1}, {32'h0, 1'b1},
             {32'h1122_3344, 1'b0}, {32'h0, 1'b1}, {32'h0, 1'b1},
             {32'h0, 1'b1}, {32'h0, 1'b0}, {32'hCAFE_F00D, 1'b0}};
    t_an = '{0, 1, 1, 1, 1, 1, 1, 1, 1};
    for (int i = 0; i < 9; i++) begin
      sb.push_back(t_e[i]);
      run(t_we[i], t_a[i], t_m[i], t_wd[i], rd, er, lat);
      e = sb.pop_front();
      n_tot++;
      if (rd !== e.rd || er !== e.er || anomaly !== t_an[i]) begin
        $display("FAIL err_%0d got rd=%h e=%b an=%b want %h %b %b",
                 i, rd, er, anomaly, e.rd, e.er, t_an[i]);
      end else n_pass++;
    end
  endtask

  task automatic test_reset_wait;
    logic [31:0] rd;
    logic er;
    int lat;
    exp_t e;
    sb.push_back({32'h0, 1'b0});
    run(1'b1, 32'h20, 3'd2, 32'h0, rd, er, lat);
    e = sb.pop_front();
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h20;
    req_mode  = 3'd2;
    req_wdata = 32'h1234_5678;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_tot++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || anomaly !== 1'b0) begin
      $display("FAIL rst_wait got v=%b rdy=%b an=%b want 0 0 0",
               rsp_valid, req_ready, anomaly);
    end else n_pass++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb.push_back({32'h0, 1'b0});
    run(1'b0, 32'h20, 3'd2, 32'h0, rd, er, lat);
    e = sb.pop_front();
    n_tot++;
    if (rd !== e.rd || er !== e.er || anomaly !== 1'b0) begin
      $display("FAIL rst_lw20 got rd=%h e=%b an=%b want %h %b 0",
               rd, er, anomaly, e.rd, e.er);
    end else n_pass++;
  endtask

  task automatic test_lat0;
    int acc;
    int first;
    logic a;
    acc = 0;
    first = 1;
    @(negedge clk);
    req_valid0 = 1'b1;
    req_we0    = 1'b1;
    req_addr0  = 32'h40;
    req_mode0  = 3'd2;
    req_wdata0 = 32'h5A5A_5A5A;
    rsp_ready0 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a = req_ready0;
      @(posedge clk);
      #1;
      if (a) acc++;
      if (a && first == 1) begin
        first = 0;
        n_tot++;
        if (rsp_valid0 !== 1'b1 || rsp_err0 !== 1'b0 ||
            rsp_rdata0 !== 32'h0) begin
          $display("FAIL lat0_first got v=%b e=%b rd=%h want 1 0 0",
                   rsp_valid0, rsp_err0, rsp_rdata0);
        end else n_pass++;
      end
      @(negedge clk);
    end
    req_valid0 = 1'b0;
    n_tot++;
    if (acc !== 5) begin
      $display("FAIL lat0_rate got accepts=%0d want 5", acc);
    end else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_addr = '0;
    req_mode = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;
    req_valid0 = 1'b0;
    req_we0 = 1'b0;
    req_addr0 = '0;
    req_mode0 = '0;
    req_wdata0 = '0;
    rsp_ready0 = 1'b0;
    test_reset();
    test_sw_lw();
    test_lanes();
    test_backpressure();
    test_errors();
    test_reset_wait();
    test_lat0();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
